// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with owner-selected slave mux and a
// no-ready watchdog that forcibly revokes a stuck grant.
module bus_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 255,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTERS-1:0]                 m_req_,
    output logic [N_MASTERS-1:0]                 m_grnt_,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS-1:0]                 m_as_,
    input  logic [N_MASTERS-1:0]                 m_rw,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]     m_wr_data,
    output logic [ADDR_W-1:0]                    s_addr,
    output logic                                 s_as_,
    output logic                                 s_rw,
    output logic [DATA_W-1:0]                    s_wr_data,
    input  logic                                 s_rdy_,
    output logic [$clog2(N_MASTERS)-1:0]         owner,
    output logic                                 owned,
    output logic                                 timeout
);

    localparam int OW_W = $clog2(N_MASTERS);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [OW_W-1:0]        r_owner, w_owner_nxt, w_pick;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic [N_MASTERS-1:0]   r_grnt_, w_grnt_nxt_;
    logic [N_MASTERS-1:0]   w_req;
    logic                   w_pick_vld;
    logic                   w_hit;

    assign w_req = ~m_req_;

    // Scan from owner+1 upward; the owner itself is considered last, so a
    // revoked master is only re-picked when nobody else is asking.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = r_owner;
        for (int i = N_MASTERS; i >= 1; i--) begin
            if (w_req[OW_W'((int'(r_owner) + i) % N_MASTERS)]) begin
                w_pick_vld = 1'b1;
                w_pick     = OW_W'((int'(r_owner) + i) % N_MASTERS);
            end
        end
    end

    assign w_hit = (TIMEOUT != 0) && (r_state == OWNED) && s_rdy_ && (r_cnt == TO_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_pick;
                end
            end
            OWNED: begin
                if (m_req_[r_owner]) begin
                    // Release wins over a coincident timeout: no pulse.
                    w_cnt_nxt = '0;
                    if (w_pick_vld) w_owner_nxt = w_pick;
                    else            w_state_nxt = IDLE;
                end else if (w_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    if (w_pick_vld) w_owner_nxt = w_pick;
                    else            w_state_nxt = IDLE;
                end else if (!s_rdy_) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_grnt_nxt_ = '1;
        if (w_state_nxt == OWNED) w_grnt_nxt_[w_owner_nxt] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_grnt_   <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_grnt_   <= w_grnt_nxt_;
        end
    end

    // Slave side is selected purely from registered ownership.
    always_comb begin
        s_addr    = '0;
        s_as_     = DISABLE_;
        s_rw      = READ;
        s_wr_data = '0;
        if (r_state == OWNED) begin
            s_addr    = m_addr[r_owner];
            s_as_     = m_as_[r_owner];
            s_rw      = m_rw[r_owner];
            s_wr_data = m_wr_data[r_owner];
        end
    end

    assign m_grnt_ = r_grnt_;
    assign owner   = r_owner;
    assign owned   = (r_state == OWNED);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed checks of bus_arbiter against a behavioural
// round-robin ownership model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam int AW = 30;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N-1:0]          m_req_ = '1;
    logic [N-1:0]          m_grnt_;
    logic [N-1:0][AW-1:0]  m_addr = '0;
    logic [N-1:0]          m_as_ = '1;
    logic [N-1:0]          m_rw = '1;
    logic [N-1:0][DW-1:0]  m_wr_data = '0;
    logic [AW-1:0]         s_addr;
    logic                  s_as_;
    logic                  s_rw;
    logic [DW-1:0]         s_wr_data;
    logic                  s_rdy_ = 1'b1;
    logic [1:0]            owner;
    logic                  owned;
    logic                  timeout;

    bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m_req_(m_req_), .m_grnt_(m_grnt_),
        .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .s_rdy_(s_rdy_), .owner(owner), .owned(owned), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: who owns the bus and for how many unready cycles.
    bit mo_owned = 1'b0;
    int mo_owner = 0;
    int mo_cnt   = 0;
    bit mo_to    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int from, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        mo_owned = 1'b0;
        mo_owner = 0;
        mo_cnt   = 0;
        mo_to    = 1'b0;
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        logic [1:0]   oi;
        eg = '1;
        oi = 2'(mo_owner);
        if (mo_owned) eg[oi] = 1'b0;
        check("grnt", 64'(m_grnt_), 64'(eg));
        check("owner", 64'(owner), 64'(oi));
        check("owned", 64'(owned), 64'(mo_owned));
        check("timeout", 64'(timeout), 64'(mo_to));
        if (mo_owned) begin
            check("s_addr", 64'(s_addr), 64'(m_addr[oi]));
            check("s_as_", 64'(s_as_), 64'(m_as_[oi]));
            check("s_rw", 64'(s_rw), 64'(m_rw[oi]));
            check("s_wdata", 64'(s_wr_data), 64'(m_wr_data[oi]));
        end else begin
            check("s_addr_idle", 64'(s_addr), 64'd0);
            check("s_as_idle", 64'(s_as_), 64'd1);
            check("s_rw_idle", 64'(s_rw), 64'd1);
            check("s_wdata_idle", 64'(s_wr_data), 64'd0);
        end
    endtask

    task automatic step(input logic [N-1:0] req_n, input logic [N-1:0] as_n, input logic rdy_n);
        logic [N-1:0] req;
        int p;
        m_req_ = req_n;
        m_as_  = as_n;
        s_rdy_ = rdy_n;
        for (int i = 0; i < N; i++) begin
            m_addr[i]    = AW'($urandom);
            m_wr_data[i] = $urandom;
            m_rw[i]      = 1'($urandom);
        end
        @(posedge clk);
        req   = ~req_n;
        p     = rr_pick(mo_owner, req);
        mo_to = 1'b0;
        if (!mo_owned) begin
            if (p >= 0) begin
                mo_owned = 1'b1;
                mo_owner = p;
                mo_cnt   = 0;
            end
        end else if (!req[mo_owner]) begin
            if (p >= 0) mo_owner = p;
            else        mo_owned = 1'b0;
            mo_cnt = 0;
        end else if (rdy_n && mo_cnt + 1 == TO) begin
            mo_to  = 1'b1;
            mo_cnt = 0;
            mo_owner = p;
        end else begin
            mo_cnt = rdy_n ? mo_cnt + 1 : 0;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        m_req_ = '1;
        m_as_  = '1;
        model_reset();
        #2;
        check_all();
        #2;
        rst = 1'b1;
    endtask

    int held;
    int prev;
    bit seen;
    logic [N-1:0] rq;

    initial begin
        #12;
        check_all();
        check("rst_grnt", 64'(m_grnt_), 64'hF);
        rst = 1'b1;

        // Single request and release
        step(~4'b0010, 4'b1101, 1'b0);
        check("single_grnt", 64'(m_grnt_), 64'b1101);
        check("single_addr", 64'(s_addr), 64'(m_addr[1]));
        for (int i = 0; i < 3; i++) step(~4'b0010, 4'b1101, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        check("release_grnt", 64'(m_grnt_), 64'hF);

        // Contention round-robin among M0, M2, M3
        do_reset();
        held = 0; seen = 1'b0; prev = 0;
        for (int c = 0; c < 30; c++) begin
            rq = 4'b1101;
            if (mo_owned && held >= 3) rq[2'(mo_owner)] = 1'b0;
            step(~rq, ~rq, 1'b0);
            if (mo_owned && (!seen || mo_owner != prev)) begin
                if (seen) check("rr_order", 64'(owner), 64'((prev == 0) ? 2 : (prev == 2) ? 3 : 0));
                seen = 1'b1;
                prev = mo_owner;
                held = 1;
            end else begin
                held++;
            end
            if (c > 0) check("rr_noidle", 64'(owned), 64'd1);
        end

        // Pointer preservation across idle
        do_reset();
        for (int i = 0; i < 3; i++) step(~4'b0100, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) step(4'hF, 4'hF, 1'b0);
        step(~4'b1001, 4'hF, 1'b0);
        check("ptr_owner", 64'(owner), 64'd3);

        // Mux isolation
        do_reset();
        step(~4'b0010, 4'hF, 1'b0);
        step(~4'b0011, 4'b1110, 1'b0);
        check("mux_iso_as", 64'(s_as_), 64'd1);
        check("mux_iso_g0", 64'(m_grnt_[0]), 64'd1);

        // Watchdog revoke, then a ready that defers it
        do_reset();
        step(~4'b1000, 4'hF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(~4'b1010, 4'hF, 1'b1);
            if (i < 8) check("wd_early", 64'(timeout), 64'd0);
        end
        check("wd_pulse", 64'(timeout), 64'd1);
        check("wd_g3", 64'(m_grnt_[3]), 64'd1);
        check("wd_g1", 64'(m_grnt_[1]), 64'd0);
        for (int j = 1; j <= 10; j++) begin
            step(~4'b1010, 4'hF, (j == 7) ? 1'b0 : 1'b1);
            check("wd_rdy_defer", 64'(timeout), 64'd0);
        end

        // Async reset while owned
        do_reset();
        step(~4'b0010, 4'b1101, 1'b0);
        step(~4'b0010, 4'b1101, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_grnt", 64'(m_grnt_), 64'hF);
        check("arst_as", 64'(s_as_), 64'd1);
        model_reset();
        #2;
        rst = 1'b1;
        step(~4'b1010, 4'hF, 1'b0);
        check("arst_rr_owner", 64'(owner), 64'd1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 3) != 0);
            step(~rq, 4'($urandom), ($urandom_range(0, 9) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
